// File: rtl/gpu_blitter.sv
// gpu_blitter: sprite blitter for the Hans2 graphics path.
// It copies a clipped rectangle from a spritesheet to the framebuffer, or it
// fills the whole framebuffer with one colour. Memory reads have a fixed
// latency of MEM_LAT cycles, and the destination coordinates travel in a
// matching delay line.
// Optional feature: define GPU_FLIP_EN to honour ctrl_flip (horizontal and
// vertical sprite flip). When it is undefined, ctrl_flip is ignored.
//
// Handshake: ctrl_draw and ctrl_clear are single-cycle strobes. They are
// accepted only in IDLE, where ctrl_busy is 0. While ctrl_busy is 1 they are
// dropped, not queued. mem_req is a valid with no ready: the memory must
// return mem_rdata exactly MEM_LAT cycles after each request. fb_write is a
// valid with no ready: the framebuffer takes a pixel in every cycle that
// fb_write is high.
module gpu_blitter #(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int MEM_LAT   = 2,
   localparam int XW = $clog2(FB_WIDTH),
   localparam int YW = $clog2(FB_HEIGHT)
) (
   input  logic          clk,
   input  logic          rstn,
   output logic          mem_req,
   output logic [31:0]   mem_addr,
   input  logic [15:0]   mem_rdata,
   input  logic [31:0]   ctrl_address,
   input  logic [15:0]   ctrl_src_x,
   input  logic [15:0]   ctrl_src_y,
   input  logic [15:0]   ctrl_sheetsize,
   input  logic [15:0]   ctrl_width,
   input  logic [15:0]   ctrl_height,
   input  logic [15:0]   ctrl_x,
   input  logic [15:0]   ctrl_y,
   input  logic [1:0]    ctrl_flip,
   input  logic          ctrl_draw,
   input  logic [15:0]   ctrl_clear_color,
   input  logic          ctrl_clear,
   output logic          ctrl_busy,
   output logic [XW-1:0] fb_x,
   output logic [YW-1:0] fb_y,
   output logic [15:0]   fb_color,
   output logic          fb_write,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, FILL = 2'd3} state_t;

   state_t        state;
   logic [31:0]   base_q;
   logic [15:0]   src_x_q, src_y_q, pitch_q, w_q, h_q, x_q, y_q;
   logic [15:0]   col, row;
   logic [1:0]    drain_cnt;
   logic          req_ok;
   logic [XW-1:0] req_x;
   logic [YW-1:0] req_y;
   logic          fill_write;
   logic [XW-1:0] fill_x;
   logic [YW-1:0] fill_y;
   logic [15:0]   fill_color;

   logic [MEM_LAT-1:0] p_ok;
   logic [XW-1:0]      p_x [MEM_LAT];
   logic [YW-1:0]      p_y [MEM_LAT];

   // In IDLE the first pixel is issued straight from the ctrl inputs.
   // After that, the latched copies are used.
   logic          idle;
   logic [31:0]   e_base;
   logic [15:0]   e_src_x, e_src_y, e_pitch, e_x, e_y;
   logic [15:0]   issue_col, issue_row, sx, sy, dx, dy;
   logic [31:0]   row_idx, addr_c;
   logic          last_col, last_px, in_range;

   assign idle    = (state == IDLE);
   assign e_base  = idle ? ctrl_address   : base_q;
   assign e_src_x = idle ? ctrl_src_x     : src_x_q;
   assign e_src_y = idle ? ctrl_src_y     : src_y_q;
   assign e_pitch = idle ? ctrl_sheetsize : pitch_q;
   assign e_x     = idle ? ctrl_x         : x_q;
   assign e_y     = idle ? ctrl_y         : y_q;

   assign last_col = (col == w_q - 16'd1);
   assign last_px  = last_col && (row == h_q - 16'd1);

   // Pick the pixel issued at the next edge: (0,0) on acceptance,
   // otherwise the row-major successor of the current pixel.
   always_comb begin
      issue_col = 16'd0;
      issue_row = 16'd0;
      if (!idle) begin
         if (last_col) begin
            issue_col = 16'd0;
            issue_row = row + 16'd1;
         end else begin
            issue_col = col + 16'd1;
            issue_row = row;
         end
      end
   end

`ifdef GPU_FLIP_EN
   logic [1:0]  flip_q;
   logic [1:0]  e_flip;
   logic [15:0] e_w, e_h;
   assign e_flip = idle ? ctrl_flip   : flip_q;
   assign e_w    = idle ? ctrl_width  : w_q;
   assign e_h    = idle ? ctrl_height : h_q;
   assign sx = e_flip[0] ? (e_w - 16'd1 - issue_col) : issue_col;
   assign sy = e_flip[1] ? (e_h - 16'd1 - issue_row) : issue_row;
`else
   logic unused_flip;
   assign unused_flip = ^ctrl_flip;
   assign sx = issue_col;
   assign sy = issue_row;
`endif

   assign row_idx  = {16'd0, e_src_y} + {16'd0, sy};
   assign addr_c   = e_base + row_idx * {16'd0, e_pitch} + {16'd0, e_src_x} + {16'd0, sx};
   assign dx       = e_x + issue_col;
   assign dy       = e_y + issue_row;
   assign in_range = !dx[15] && (dx < 16'(FB_WIDTH)) && !dy[15] && (dy < 16'(FB_HEIGHT));

   // Control FSM: accepts commands, steps the read and fill counters,
   // and registers mem_req, mem_addr and ctrl_busy.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         ctrl_busy  <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= 32'd0;
         req_ok     <= 1'b0;
         req_x      <= '0;
         req_y      <= '0;
         col        <= 16'd0;
         row        <= 16'd0;
         drain_cnt  <= 2'd0;
         fill_write <= 1'b0;
         fill_x     <= '0;
         fill_y     <= '0;
         fill_color <= 16'd0;
         base_q     <= 32'd0;
         src_x_q    <= 16'd0;
         src_y_q    <= 16'd0;
         pitch_q    <= 16'd0;
         w_q        <= 16'd0;
         h_q        <= 16'd0;
         x_q        <= 16'd0;
         y_q        <= 16'd0;
`ifdef GPU_FLIP_EN
         flip_q     <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (ctrl_clear) begin
                  state      <= FILL;
                  ctrl_busy  <= 1'b1;
                  fill_write <= 1'b1;
                  fill_x     <= '0;
                  fill_y     <= '0;
                  fill_color <= ctrl_clear_color;
               end else if (ctrl_draw) begin
                  ctrl_busy <= 1'b1;
                  base_q    <= ctrl_address;
                  src_x_q   <= ctrl_src_x;
                  src_y_q   <= ctrl_src_y;
                  pitch_q   <= ctrl_sheetsize;
                  w_q       <= ctrl_width;
                  h_q       <= ctrl_height;
                  x_q       <= ctrl_x;
                  y_q       <= ctrl_y;
`ifdef GPU_FLIP_EN
                  flip_q    <= ctrl_flip;
`endif
                  if (ctrl_width == 16'd0 || ctrl_height == 16'd0) begin
                     state     <= DRAIN;
                     drain_cnt <= 2'd0;
                  end else begin
                     state    <= FETCH;
                     mem_req  <= 1'b1;
                     mem_addr <= addr_c;
                     req_ok   <= in_range;
                     req_x    <= dx[XW-1:0];
                     req_y    <= dy[YW-1:0];
                     col      <= issue_col;
                     row      <= issue_row;
                  end
               end
            end
            FETCH: begin
               if (last_px) begin
                  state     <= DRAIN;
                  mem_req   <= 1'b0;
                  req_ok    <= 1'b0;
                  drain_cnt <= 2'd0;
               end else begin
                  mem_addr <= addr_c;
                  req_ok   <= in_range;
                  req_x    <= dx[XW-1:0];
                  req_y    <= dy[YW-1:0];
                  col      <= issue_col;
                  row      <= issue_row;
               end
            end
            DRAIN: begin
               if (drain_cnt == 2'(MEM_LAT - 1)) begin
                  state     <= IDLE;
                  ctrl_busy <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            FILL: begin
               if (fill_x == XW'(FB_WIDTH - 1) && fill_y == YW'(FB_HEIGHT - 1)) begin
                  state      <= IDLE;
                  ctrl_busy  <= 1'b0;
                  fill_write <= 1'b0;
               end else if (fill_x == XW'(FB_WIDTH - 1)) begin
                  fill_x <= '0;
                  fill_y <= fill_y + YW'(1);
               end else begin
                  fill_x <= fill_x + XW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Delay line that carries each request's destination until its read data returns.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         p_ok <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            p_x[i] <= '0;
            p_y[i] <= '0;
         end
      end else begin
         p_ok[0] <= mem_req & req_ok;
         p_x[0]  <= req_x;
         p_y[0]  <= req_y;
         for (int i = 1; i < MEM_LAT; i++) begin
            p_ok[i] <= p_ok[i-1];
            p_x[i]  <= p_x[i-1];
            p_y[i]  <= p_y[i-1];
         end
      end
   end

   // Draw data takes the framebuffer port when a delayed request lands.
   // Otherwise the fill registers drive it.
   always_comb begin
      fb_write = fill_write | (p_ok[MEM_LAT-1] & mem_rdata[0]);
      fb_x     = p_ok[MEM_LAT-1] ? p_x[MEM_LAT-1] : fill_x;
      fb_y     = p_ok[MEM_LAT-1] ? p_y[MEM_LAT-1] : fill_y;
      fb_color = p_ok[MEM_LAT-1] ? mem_rdata      : fill_color;
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_gpu_blitter.sv
// tb_gpu_blitter: directed bench for gpu_blitter on a 4x3 framebuffer with MEM_LAT=2.
// Expected memory requests and framebuffer writes are stamped with the cycle
// in which they must appear, and a negedge monitor checks them in order.
module tb_gpu_blitter;

   localparam int FBW = 4;
   localparam int FBH = 3;
   localparam int LAT = 2;
   localparam int XW  = $clog2(FBW);
   localparam int YW  = $clog2(FBH);

   logic          clk = 1'b0;
   logic          rstn;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [15:0]   mem_rdata = 16'd0;
   logic [31:0]   ctrl_address;
   logic [15:0]   ctrl_src_x, ctrl_src_y, ctrl_sheetsize, ctrl_width, ctrl_height, ctrl_x, ctrl_y;
   logic [1:0]    ctrl_flip;
   logic          ctrl_draw;
   logic [15:0]   ctrl_clear_color;
   logic          ctrl_clear;
   logic          ctrl_busy;
   logic [XW-1:0] fb_x;
   logic [YW-1:0] fb_y;
   logic [15:0]   fb_color;
   logic          fb_write;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic mon_en = 1'b0;

   // Scoreboard entries: {cycle[15:0], addr[31:0]} and {cycle[15:0], x[7:0], y[7:0], color[15:0]}.
   logic [47:0] req_q[$];
   logic [47:0] exp_q[$];

   logic [15:0] mem [0:511];
   logic [31:0] rd_a0;

   gpu_blitter #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .MEM_LAT(LAT)) dut (
      .clk(clk), .rstn(rstn),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ctrl_address(ctrl_address), .ctrl_src_x(ctrl_src_x), .ctrl_src_y(ctrl_src_y),
      .ctrl_sheetsize(ctrl_sheetsize), .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
      .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_flip(ctrl_flip), .ctrl_draw(ctrl_draw),
      .ctrl_clear_color(ctrl_clear_color), .ctrl_clear(ctrl_clear), .ctrl_busy(ctrl_busy),
      .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Fixed-latency memory model: data for a request comes back LAT cycles later.
   always @(posedge clk) begin
      rd_a0     <= mem_addr;
      mem_rdata <= mem[rd_a0[8:0]];
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] wr_word(input int t, input int x, input int y, input logic [15:0] c);
      return {16'(t), 8'(x), 8'(y), c};
   endfunction

   function automatic logic [47:0] rq_word(input int t, input logic [31:0] a);
      return {16'(t), a};
   endfunction

   // Monitor: every request and every write must match the head of its queue.
   always @(negedge clk) begin
      if (mon_en && rstn === 1'b1) begin
         if (mem_req === 1'b1) begin
            if (req_q.size() == 0) check_eq("req_unexpected", 64'd1, 64'd0);
            else check_eq("req", {16'd0, 16'(cyc), mem_addr}, {16'd0, req_q.pop_front()});
         end
         if (fb_write === 1'b1) begin
            if (exp_q.size() == 0) check_eq("wr_unexpected", 64'd1, 64'd0);
            else check_eq("wr", {16'd0, 16'(cyc), 8'(fb_x), 8'(fb_y), fb_color}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_slot(output int t0);
      @(negedge clk);
      t0 = cyc + 1;
   endtask

   task automatic issue_cmd(input logic drw, input logic clr, input logic [31:0] base,
                            input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] pitch,
                            input logic [15:0] w, input logic [15:0] h, input logic [15:0] x,
                            input logic [15:0] y, input logic [1:0] flip, input logic [15:0] color);
      ctrl_address     = base;
      ctrl_src_x       = sx;
      ctrl_src_y       = sy;
      ctrl_sheetsize   = pitch;
      ctrl_width       = w;
      ctrl_height      = h;
      ctrl_x           = x;
      ctrl_y           = y;
      ctrl_flip        = flip;
      ctrl_clear_color = color;
      ctrl_draw        = drw;
      ctrl_clear       = clr;
      @(negedge clk);
      ctrl_draw        = 1'b0;
      ctrl_clear       = 1'b0;
      // Scramble the command inputs: the accepted command must not see this.
      ctrl_address     = $urandom;
      ctrl_src_x       = 16'($urandom_range(0, 65535));
      ctrl_src_y       = 16'($urandom_range(0, 65535));
      ctrl_sheetsize   = 16'($urandom_range(0, 65535));
      ctrl_width       = 16'($urandom_range(0, 65535));
      ctrl_height      = 16'($urandom_range(0, 65535));
      ctrl_x           = 16'($urandom_range(0, 65535));
      ctrl_y           = 16'($urandom_range(0, 65535));
      ctrl_flip        = 2'($urandom_range(0, 3));
      ctrl_clear_color = 16'($urandom_range(0, 65535));
   endtask

   task automatic wait_idle(input string tag, input int exp_len);
      int n = 0;
      while (ctrl_busy === 1'b1 && n < 500) begin
         n++;
         @(negedge clk);
      end
      check_eq(tag, 64'(n), 64'(exp_len));
   endtask

   task automatic drain_check(input string tag);
      repeat (4) @(negedge clk);
      check_eq({tag, "_req_left"}, 64'(req_q.size()), 64'd0);
      check_eq({tag, "_wr_left"}, 64'(exp_q.size()), 64'd0);
      req_q.delete();
      exp_q.delete();
   endtask

   task automatic push_clear(input int t0, input logic [15:0] c);
      for (int i = 0; i < FBW * FBH; i++) exp_q.push_back(wr_word(t0 + i, i % FBW, i / FBW, c));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      logic [31:0] fa0, fa2;
      logic [15:0] fc0, fc2;

      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      mem[9'h102] = 16'hA001; mem[9'h103] = 16'hB003;
      mem[9'h10A] = 16'hC005; mem[9'h10B] = 16'hD007;
      mem[9'h000] = 16'h0001; mem[9'h001] = 16'h0000; mem[9'h002] = 16'h0003;
      mem[9'h040] = 16'h1001; mem[9'h041] = 16'h2003; mem[9'h042] = 16'h3005;
      mem[9'h050] = 16'h0007; mem[9'h051] = 16'h0009;

      rstn = 1'b0;
      ctrl_address = 32'd0; ctrl_src_x = 16'd0; ctrl_src_y = 16'd0; ctrl_sheetsize = 16'd0;
      ctrl_width = 16'd0; ctrl_height = 16'd0; ctrl_x = 16'd0; ctrl_y = 16'd0;
      ctrl_flip = 2'd0; ctrl_draw = 1'b0; ctrl_clear_color = 16'd0; ctrl_clear = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_busy", 64'(ctrl_busy), 64'd0);
      check_eq("rst_mem_req", 64'(mem_req), 64'd0);
      check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_eq("rst_fb_write", 64'(fb_write), 64'd0);
      check_eq("rst_fb_x", 64'(fb_x), 64'd0);
      check_eq("rst_fb_y", 64'(fb_y), 64'd0);
      check_eq("rst_fb_color", 64'(fb_color), 64'd0);
      rstn = 1'b1;
      mon_en = 1'b1;

      // Clear with 0x1235: 12 row-major writes, busy 12 cycles
      wait_slot(t0);
      push_clear(t0, 16'h1235);
      issue_cmd(1'b0, 1'b1, 32'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0, 16'h1235);
      wait_idle("clear_busy", 12);
      drain_check("clear");

      // 2x2 draw at (1,1), pitch 8, src (2,0), base 0x100
      wait_slot(t0);
      req_q.push_back(rq_word(t0,     32'h102));
      req_q.push_back(rq_word(t0 + 1, 32'h103));
      req_q.push_back(rq_word(t0 + 2, 32'h10A));
      req_q.push_back(rq_word(t0 + 3, 32'h10B));
      exp_q.push_back(wr_word(t0 + 2, 1, 1, 16'hA001));
      exp_q.push_back(wr_word(t0 + 3, 2, 1, 16'hB003));
      exp_q.push_back(wr_word(t0 + 4, 1, 2, 16'hC005));
      exp_q.push_back(wr_word(t0 + 5, 2, 2, 16'hD007));
      issue_cmd(1'b1, 1'b0, 32'h100, 16'd2, 16'd0, 16'd8, 16'd2, 16'd2, 16'd1, 16'd1, 2'd0, 16'd0);
      wait_idle("draw2x2_busy", 6);
      drain_check("draw2x2");

      // 3x1 draw at x=-1, y=2: left pixel clipped, middle transparent
      wait_slot(t0);
      req_q.push_back(rq_word(t0,     32'h000));
      req_q.push_back(rq_word(t0 + 1, 32'h001));
      req_q.push_back(rq_word(t0 + 2, 32'h002));
      exp_q.push_back(wr_word(t0 + 4, 1, 2, 16'h0003));
      issue_cmd(1'b1, 1'b0, 32'h000, 16'd0, 16'd0, 16'd8, 16'd3, 16'd1, 16'hFFFF, 16'd2, 2'd0, 16'd0);
      wait_idle("clipl_busy", 5);
      drain_check("clipl");

      // 2x1 draw at x=3: right pixel lands at x=FB_WIDTH and is clipped
      wait_slot(t0);
      req_q.push_back(rq_word(t0,     32'h050));
      req_q.push_back(rq_word(t0 + 1, 32'h051));
      exp_q.push_back(wr_word(t0 + 2, 3, 0, 16'h0007));
      issue_cmd(1'b1, 1'b0, 32'h050, 16'd0, 16'd0, 16'd8, 16'd2, 16'd1, 16'd3, 16'd0, 2'd0, 16'd0);
      wait_idle("clipr_busy", 4);
      drain_check("clipr");

      // Horizontal flip of a 3x1 sprite (ignored when the flip option is absent)
`ifdef GPU_FLIP_EN
      fa0 = 32'h042; fa2 = 32'h040; fc0 = 16'h3005; fc2 = 16'h1001;
`else
      fa0 = 32'h040; fa2 = 32'h042; fc0 = 16'h1001; fc2 = 16'h3005;
`endif
      wait_slot(t0);
      req_q.push_back(rq_word(t0,     fa0));
      req_q.push_back(rq_word(t0 + 1, 32'h041));
      req_q.push_back(rq_word(t0 + 2, fa2));
      exp_q.push_back(wr_word(t0 + 2, 0, 0, fc0));
      exp_q.push_back(wr_word(t0 + 3, 1, 0, 16'h2003));
      exp_q.push_back(wr_word(t0 + 4, 2, 0, fc2));
      issue_cmd(1'b1, 1'b0, 32'h040, 16'd0, 16'd0, 16'd8, 16'd3, 16'd1, 16'd0, 16'd0, 2'b01, 16'd0);
      wait_idle("flip_busy", 5);
      drain_check("flip");

      // Empty draw (W=0): no requests, no writes, busy MEM_LAT
      wait_slot(t0);
      issue_cmd(1'b1, 1'b0, 32'h100, 16'd0, 16'd0, 16'd8, 16'd0, 16'd3, 16'd0, 16'd0, 2'd0, 16'd0);
      wait_idle("empty_busy", LAT);
      drain_check("empty");

      // Draw pulsed during a clear is dropped
      wait_slot(t0);
      push_clear(t0, 16'h0F0F);
      issue_cmd(1'b0, 1'b1, 32'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0, 16'h0F0F);
      ctrl_address = 32'h100; ctrl_width = 16'd1; ctrl_height = 16'd1; ctrl_sheetsize = 16'd8;
      ctrl_x = 16'd0; ctrl_y = 16'd0; ctrl_draw = 1'b1;
      @(negedge clk);
      ctrl_draw = 1'b0;
      wait_idle("busy_drop_busy", 11);
      drain_check("busy_drop");

      // Draw and clear together in IDLE: clear wins
      wait_slot(t0);
      push_clear(t0, 16'h0ABC);
      issue_cmd(1'b1, 1'b1, 32'h100, 16'd2, 16'd0, 16'd8, 16'd2, 16'd2, 16'd1, 16'd1, 2'd0, 16'h0ABC);
      wait_idle("both_busy", 12);
      drain_check("both");

      // Reset in the middle of a draw: nothing more from the aborted command
      mon_en = 1'b0;
      wait_slot(t0);
      issue_cmd(1'b1, 1'b0, 32'h100, 16'd2, 16'd0, 16'd8, 16'd2, 16'd2, 16'd1, 16'd1, 2'd0, 16'd0);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 64'(ctrl_busy), 64'd0);
      check_eq("abort_fb_write", 64'(fb_write), 64'd0);
      check_eq("abort_mem_req", 64'(mem_req), 64'd0);
      rstn = 1'b1;
      mon_en = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("abort_idle", 64'(ctrl_busy), 64'd0);
      drain_check("abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
